d5m_stream_gen: RTL and testbench
=================================

Name: d5m_stream_gen

Overview:
- Synthetic D5M-style pixel-stream transmitter: drives FVAL/LVAL/12-bit Bayer data with the same framing the capture path consumes.
- Lets the capture → RAW2RGB → SDRAM → VGA chain run and be verified without a sensor; in hardware it muxes in front of the rCCD_* registers.
- Frame-atomic start/stop, four selectable test patterns, frame counter for the 7-seg display.

Parameters:
- H_ACTIVE, 1280, pixels per line (LVAL-high cycles); range 2..4095.
- V_ACTIVE, 960, lines per frame; range 2..65535.
- H_BLANK, 64, LVAL-low cycles between lines inside a frame; minimum 1.
- FV_LEAD, 8, cycles FVAL is high before the first LVAL; minimum 1.
- FV_TRAIL, 8, cycles FVAL stays high after the last LVAL; minimum 1.
- V_BLANK, 32, cycles FVAL is low between frames; minimum 1.
- CHK_LOG2, 5, checkerboard square size = 2^CHK_LOG2 pixels.

Ports:
- iCLK  in  1  pixel clock; all logic on the rising edge.
- iRST  in  1  synchronous reset, active-high.
- iSTART  in  1  single-cycle start request.
- iEND  in  1  single-cycle stop request; takes effect at the end of the current frame.
- iPATTERN  in  2  pattern select, sampled at frame start.
- oDATA  out  12  pixel data; 0 whenever oLVAL=0.
- oFVAL  out  1  frame valid.
- oLVAL  out  1  line valid.
- oX_Cont  out  16  column of the current pixel; 0 when oLVAL=0.
- oY_Cont  out  16  line index within the frame.
- oFrame_Cont  out  32  number of completed frames.
- oBUSY  out  1  high from frame start until the final V_BLANK completes.

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset also forces state IDLE and clears the stop-pending flag.
- Reset mid-frame: outputs go to 0 on the next edge. The partial frame is abandoned and oFrame_Cont is not incremented.
- States:
  - IDLE
  - LEAD: FVAL=1, LVAL=0, FV_LEAD cycles.
  - ACTIVE: FVAL=1, LVAL=1, H_ACTIVE cycles.
  - HBLANK: FVAL=1, LVAL=0, H_BLANK cycles.
  - TRAIL: FVAL=1, LVAL=0, FV_TRAIL cycles.
  - VBLANK: FVAL=0, LVAL=0, V_BLANK cycles.
- Transitions:
  - IDLE → LEAD when iSTART=1 and iEND=0. Outputs reflect LEAD on the cycle after the request edge.
  - LEAD → ACTIVE.
  - ACTIVE → HBLANK if oY_Cont < V_ACTIVE-1, else ACTIVE → TRAIL.
  - HBLANK → ACTIVE, with oY_Cont incremented.
  - TRAIL → VBLANK. oFrame_Cont increments on the same edge oFVAL falls; it wraps at 2^32 with no saturation.
  - VBLANK → LEAD if stop-pending=0, else VBLANK → IDLE and stop-pending is cleared.
- Frame timing: FVAL-high length = FV_LEAD + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + FV_TRAIL. Frame period = FVAL-high length + V_BLANK.
- Stop handling:
  - iEND while busy sets stop-pending.
  - iSTART while busy clears stop-pending.
  - iEND and iSTART in the same cycle: iEND wins in all states.
  - iSTART while busy and not stop-pending: ignored.
- Counters:
  - oX_Cont counts 0..H_ACTIVE-1 during ACTIVE.
  - oY_Cont resets to 0 in LEAD and holds its value through TRAIL and VBLANK.
- Pattern latch: iPATTERN is latched on entry to LEAD and stays constant for the whole frame.
- Pattern values during ACTIVE, using X=oX_Cont and Y=oY_Cont:
  - 0, horizontal ramp: X[11:0].
  - 1, vertical ramp: Y[11:0].
  - 2, checkerboard: 12'hFFF if X[CHK_LOG2]^Y[CHK_LOG2], else 12'h000.
  - 3, Bayer flat: even row/even col G=12'h800, even/odd R=12'hFFF, odd/even B=12'h100, odd/odd G=12'h800.
- oDATA, oX_Cont and the FVAL/LVAL flags for a given pixel appear on the same cycle, so there is zero skew between them.

Test Plan:
Bench parameters: H_ACTIVE=8, V_ACTIVE=4, H_BLANK=3, FV_LEAD=2, FV_TRAIL=2, V_BLANK=5, CHK_LOG2=1.
- Reset then iSTART pulse, iPATTERN=0 → oFVAL high for exactly 45 cycles. oLVAL rises 2 cycles after oFVAL. There are 4 LVAL bursts of 8 cycles separated by 3-cycle gaps. oDATA=0..7 in each line. Frame period is 50 cycles.
- Free-run 3 frames, then iEND mid-frame 3 → frame 3 completes in full. oFrame_Cont=3 and oBUSY=0 after its VBLANK. oFVAL stays 0 afterward.
- iPATTERN=3 → line 0 outputs 800,FFF,800,FFF,…; line 1 outputs 100,800,100,800,…. Changing iPATTERN to 1 mid-frame has no effect until the next LEAD, where lines then read 0,1,2,3.
- iPATTERN=2 → line 0 outputs 000,000,FFF,FFF,000,000,FFF,FFF. Lines 2–3 are inverted relative to lines 0–1.
- iSTART and iEND in the same cycle while IDLE → no frame starts and outputs stay 0.
- iEND then iSTART in the same frame → the next frame still starts.
- Assert iRST during ACTIVE of line 2 → on the next edge all outputs are 0 and oFrame_Cont=0. A later iSTART produces a complete 45-cycle FVAL.

Source files
------------

// File: rtl/d5m_stream_gen.sv
// Synthetic D5M-style pixel-stream source. It produces FVAL/LVAL framing and 12-bit Bayer test data,
// so the capture -> RAW2RGB -> SDRAM -> VGA chain can run without a sensor attached.
module d5m_stream_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 960,
    parameter int H_BLANK  = 64,
    parameter int FV_LEAD  = 8,
    parameter int FV_TRAIL = 8,
    parameter int V_BLANK  = 32,
    parameter int CHK_LOG2 = 5
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iEND,
    input  logic [1:0]  iPATTERN,
    output logic [11:0] oDATA,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [15:0] oX_Cont,
    output logic [15:0] oY_Cont,
    output logic [31:0] oFrame_Cont,
    output logic        oBUSY
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEAD   = 3'd1,
        S_ACTIVE = 3'd2,
        S_HBLANK = 3'd3,
        S_TRAIL  = 3'd4,
        S_VBLANK = 3'd5
    } state_t;

    localparam logic [31:0] LEAD_LAST  = 32'(FV_LEAD - 1);
    localparam logic [31:0] HACT_LAST  = 32'(H_ACTIVE - 1);
    localparam logic [31:0] HBLK_LAST  = 32'(H_BLANK - 1);
    localparam logic [31:0] TRAIL_LAST = 32'(FV_TRAIL - 1);
    localparam logic [31:0] VBLK_LAST  = 32'(V_BLANK - 1);
    localparam logic [15:0] VACT_LAST  = 16'(V_ACTIVE - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] y_q, y_d;
    logic [1:0]  pat_q, pat_d;
    logic        stop_q, stop_d;
    logic [31:0] frame_q, frame_d;
    logic [11:0] data_q, data_d;
    logic        fval_q, fval_d;
    logic        lval_q, lval_d;
    logic [15:0] x_q, x_d;
    logic        busy_q, busy_d;
    logic        stop_req;

    // Pixel value for a given pattern and position; X/Y only need their low 12 bits.
    function automatic logic [11:0] pixel(input logic [1:0] pat, input logic [11:0] x,
                                          input logic [11:0] y);
        logic [11:0] v;
        case (pat)
            2'd0: v = x;
            2'd1: v = y;
            2'd2: v = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? 12'hFFF : 12'h000;
            2'd3: begin
                case ({y[0], x[0]})
                    2'b00:   v = 12'h800;
                    2'b01:   v = 12'hFFF;
                    2'b10:   v = 12'h100;
                    2'b11:   v = 12'h800;
                    default: v = 12'h000;
                endcase
            end
            default: v = 12'h000;
        endcase
        return v;
    endfunction

    // Next-state, counter and output computation; outputs are derived from the next state so the
    // registered flags, data and column always line up on the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        pat_d   = pat_q;
        frame_d = frame_q;

        // iEND beats iSTART; requests only matter once a frame sequence is running.
        if (state_q != S_IDLE) begin
            if (iEND) begin
                stop_req = 1'b1;
            end else if (iSTART) begin
                stop_req = 1'b0;
            end else begin
                stop_req = stop_q;
            end
        end else begin
            stop_req = stop_q;
        end
        stop_d = stop_req;

        case (state_q)
            S_IDLE: begin
                if (iSTART && !iEND) begin
                    state_d = S_LEAD;
                    cnt_d   = 32'd0;
                    y_d     = 16'd0;
                    pat_d   = iPATTERN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEAD: begin
                if (cnt_q == LEAD_LAST) begin
                    state_d = S_ACTIVE;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_ACTIVE: begin
                if (cnt_q == HACT_LAST) begin
                    cnt_d = 32'd0;
                    if (y_q < VACT_LAST) begin
                        state_d = S_HBLANK;
                    end else begin
                        state_d = S_TRAIL;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_HBLANK: begin
                if (cnt_q == HBLK_LAST) begin
                    state_d = S_ACTIVE;
                    cnt_d   = 32'd0;
                    y_d     = y_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_TRAIL: begin
                if (cnt_q == TRAIL_LAST) begin
                    state_d = S_VBLANK;
                    cnt_d   = 32'd0;
                    frame_d = frame_q + 32'd1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_VBLANK: begin
                if (cnt_q == VBLK_LAST) begin
                    cnt_d = 32'd0;
                    if (stop_req) begin
                        state_d = S_IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = S_LEAD;
                        y_d     = 16'd0;
                        pat_d   = iPATTERN;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 32'd0;
            end
        endcase

        fval_d = (state_d == S_LEAD) || (state_d == S_ACTIVE) ||
                 (state_d == S_HBLANK) || (state_d == S_TRAIL);
        lval_d = (state_d == S_ACTIVE);
        busy_d = (state_d != S_IDLE);

        if (lval_d) begin
            x_d    = cnt_d[15:0];
            data_d = pixel(pat_d, cnt_d[11:0], y_d[11:0]);
        end else begin
            x_d    = 16'd0;
            data_d = 12'd0;
        end
    end

    // State and output registers with synchronous reset; a reset abandons any partial frame.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= S_IDLE;
            cnt_q   <= 32'd0;
            y_q     <= 16'd0;
            pat_q   <= 2'd0;
            stop_q  <= 1'b0;
            frame_q <= 32'd0;
            data_q  <= 12'd0;
            fval_q  <= 1'b0;
            lval_q  <= 1'b0;
            x_q     <= 16'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            pat_q   <= pat_d;
            stop_q  <= stop_d;
            frame_q <= frame_d;
            data_q  <= data_d;
            fval_q  <= fval_d;
            lval_q  <= lval_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
        end
    end

    assign oDATA       = data_q;
    assign oFVAL       = fval_q;
    assign oLVAL       = lval_q;
    assign oX_Cont     = x_q;
    assign oY_Cont     = y_q;
    assign oFrame_Cont = frame_q;
    assign oBUSY       = busy_q;

endmodule

// File: tb/tb_d5m_stream_gen.sv
// Directed bench for d5m_stream_gen with small frame geometry: 8x4 active, frame period 50 cycles.
module tb_d5m_stream_gen;

    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [1:0]  pat;
    logic [11:0] o_data;
    logic        o_fval, o_lval, o_busy;
    logic [15:0] o_x, o_y;
    logic [31:0] o_frame;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    d5m_stream_gen #(
        .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(3), .FV_LEAD(2),
        .FV_TRAIL(2), .V_BLANK(5), .CHK_LOG2(1)
    ) dut (
        .iCLK(clk), .iRST(rst), .iSTART(start), .iEND(stop), .iPATTERN(pat),
        .oDATA(o_data), .oFVAL(o_fval), .oLVAL(o_lval), .oX_Cont(o_x),
        .oY_Cont(o_y), .oFrame_Cont(o_frame), .oBUSY(o_busy)
    );

    typedef struct {
        int          grp;
        int          idx;
        logic        fv;
        logic        lv;
        logic [11:0] d;
        logic [15:0] x;
        logic [15:0] y;
    } vec_t;

    vec_t tbl[$];

    localparam int BUF = 400;
    logic        fv_b[BUF];
    logic        lv_b[BUF];
    logic        bz_b[BUF];
    logic [11:0] dt_b[BUF];
    logic [15:0] xc_b[BUF];
    logic [15:0] yc_b[BUF];
    logic [31:0] fc_b[BUF];
    int          cur;

    function automatic void add(int g, int i, logic fv, logic lv, logic [11:0] d,
                                logic [15:0] x, logic [15:0] y);
        vec_t v;
        v.grp = g; v.idx = i; v.fv = fv; v.lv = lv; v.d = d; v.x = x; v.y = y;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (cur < BUF) begin
            fv_b[cur] = o_fval; lv_b[cur] = o_lval; bz_b[cur] = o_busy;
            dt_b[cur] = o_data; xc_b[cur] = o_x; yc_b[cur] = o_y; fc_b[cur] = o_frame;
            cur++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        step(); step();
        rst = 1'b0;
        cur = 0;
    endtask

    task automatic run_table(input int g);
        foreach (tbl[k]) begin
            if (tbl[k].grp == g) begin
                chk($sformatf("g%0d_i%0d_fval", g, tbl[k].idx), 32'(fv_b[tbl[k].idx]), 32'(tbl[k].fv));
                chk($sformatf("g%0d_i%0d_lval", g, tbl[k].idx), 32'(lv_b[tbl[k].idx]), 32'(tbl[k].lv));
                chk($sformatf("g%0d_i%0d_data", g, tbl[k].idx), 32'(dt_b[tbl[k].idx]), 32'(tbl[k].d));
                chk($sformatf("g%0d_i%0d_x", g, tbl[k].idx), 32'(xc_b[tbl[k].idx]), 32'(tbl[k].x));
                chk($sformatf("g%0d_i%0d_y", g, tbl[k].idx), 32'(yc_b[tbl[k].idx]), 32'(tbl[k].y));
            end
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_fval"}, 32'(o_fval), 32'd0);
        chk({nm, "_lval"}, 32'(o_lval), 32'd0);
        chk({nm, "_data"}, 32'(o_data), 32'd0);
        chk({nm, "_x"}, 32'(o_x), 32'd0);
        chk({nm, "_y"}, 32'(o_y), 32'd0);
        chk({nm, "_frame"}, o_frame, 32'd0);
        chk({nm, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_fv, n_lv, n_rise, n_bad, first_lv, low_idx;

        // Group 0: pattern 0 frame; lines at 2-9, 13-20, 24-31, 35-42; trail 43-44; vblank 45-49
        add(0, 0,  1'b1, 1'b0, 12'h000, 16'd0, 16'd0);
        add(0, 1,  1'b1, 1'b0, 12'h000, 16'd0, 16'd0);
        add(0, 2,  1'b1, 1'b1, 12'h000, 16'd0, 16'd0);
        add(0, 5,  1'b1, 1'b1, 12'h003, 16'd3, 16'd0);
        add(0, 9,  1'b1, 1'b1, 12'h007, 16'd7, 16'd0);
        add(0, 10, 1'b1, 1'b0, 12'h000, 16'd0, 16'd0);
        add(0, 12, 1'b1, 1'b0, 12'h000, 16'd0, 16'd0);
        add(0, 13, 1'b1, 1'b1, 12'h000, 16'd0, 16'd1);
        add(0, 20, 1'b1, 1'b1, 12'h007, 16'd7, 16'd1);
        add(0, 35, 1'b1, 1'b1, 12'h000, 16'd0, 16'd3);
        add(0, 42, 1'b1, 1'b1, 12'h007, 16'd7, 16'd3);
        add(0, 43, 1'b1, 1'b0, 12'h000, 16'd0, 16'd3);
        add(0, 44, 1'b1, 1'b0, 12'h000, 16'd0, 16'd3);
        add(0, 45, 1'b0, 1'b0, 12'h000, 16'd0, 16'd3);
        add(0, 49, 1'b0, 1'b0, 12'h000, 16'd0, 16'd3);
        add(0, 50, 1'b1, 1'b0, 12'h000, 16'd0, 16'd0);
        // Group 1: Bayer flat, then pattern 1 in the following frame
        add(1, 2,  1'b1, 1'b1, 12'h800, 16'd0, 16'd0);
        add(1, 3,  1'b1, 1'b1, 12'hFFF, 16'd1, 16'd0);
        add(1, 4,  1'b1, 1'b1, 12'h800, 16'd2, 16'd0);
        add(1, 9,  1'b1, 1'b1, 12'hFFF, 16'd7, 16'd0);
        add(1, 13, 1'b1, 1'b1, 12'h100, 16'd0, 16'd1);
        add(1, 14, 1'b1, 1'b1, 12'h800, 16'd1, 16'd1);
        add(1, 20, 1'b1, 1'b1, 12'h800, 16'd7, 16'd1);
        add(1, 22, 1'b1, 1'b0, 12'h000, 16'd0, 16'd1);
        add(1, 24, 1'b1, 1'b1, 12'h800, 16'd0, 16'd2);
        add(1, 25, 1'b1, 1'b1, 12'hFFF, 16'd1, 16'd2);
        add(1, 52, 1'b1, 1'b1, 12'h000, 16'd0, 16'd0);
        add(1, 59, 1'b1, 1'b1, 12'h000, 16'd7, 16'd0);
        add(1, 63, 1'b1, 1'b1, 12'h001, 16'd0, 16'd1);
        add(1, 74, 1'b1, 1'b1, 12'h002, 16'd0, 16'd2);
        add(1, 92, 1'b1, 1'b1, 12'h003, 16'd7, 16'd3);
        // Group 2: checkerboard with 2-pixel squares
        add(2, 2,  1'b1, 1'b1, 12'h000, 16'd0, 16'd0);
        add(2, 3,  1'b1, 1'b1, 12'h000, 16'd1, 16'd0);
        add(2, 4,  1'b1, 1'b1, 12'hFFF, 16'd2, 16'd0);
        add(2, 5,  1'b1, 1'b1, 12'hFFF, 16'd3, 16'd0);
        add(2, 6,  1'b1, 1'b1, 12'h000, 16'd4, 16'd0);
        add(2, 9,  1'b1, 1'b1, 12'hFFF, 16'd7, 16'd0);
        add(2, 13, 1'b1, 1'b1, 12'h000, 16'd0, 16'd1);
        add(2, 15, 1'b1, 1'b1, 12'hFFF, 16'd2, 16'd1);
        add(2, 24, 1'b1, 1'b1, 12'hFFF, 16'd0, 16'd2);
        add(2, 26, 1'b1, 1'b1, 12'h000, 16'd2, 16'd2);
        add(2, 35, 1'b1, 1'b1, 12'hFFF, 16'd0, 16'd3);
        add(2, 42, 1'b1, 1'b1, 12'h000, 16'd7, 16'd3);

        rst = 1'b1; start = 1'b0; stop = 1'b0; pat = 2'd0; cur = 0;
        step(); step();
        chk_all_zero("reset");
        rst = 1'b0;

        // Single frame framing with pattern 0
        cur = 0;
        for (int i = 0; i < 60; i++) begin
            start = (i == 0);
            step();
        end
        start = 1'b0;
        run_table(0);
        n_fv = 0; n_lv = 0; n_rise = 0; n_bad = 0; first_lv = -1;
        for (int i = 0; i < 50; i++) begin
            if (fv_b[i]) n_fv++;
            if (lv_b[i]) begin
                n_lv++;
                if (first_lv < 0) first_lv = i;
                if (dt_b[i] != 12'(xc_b[i])) n_bad++;
            end
            if (i > 0 && lv_b[i] && !lv_b[i-1]) n_rise++;
        end
        chk("fval_len", 32'(n_fv), 32'd45);
        chk("lval_cycles", 32'(n_lv), 32'd32);
        chk("lval_bursts", 32'(n_rise), 32'd4);
        chk("first_lval", 32'(first_lv), 32'd2);
        chk("ramp_data", 32'(n_bad), 32'd0);
        chk("frame_before_fall", fc_b[44], 32'd0);
        chk("frame_at_fall", fc_b[45], 32'd1);

        // Bayer flat, pattern select changed mid-frame
        do_reset();
        pat = 2'd3;
        for (int i = 0; i < 100; i++) begin
            start = (i == 0);
            if (i == 20) pat = 2'd1;
            step();
        end
        start = 1'b0;
        run_table(1);

        // Checkerboard
        do_reset();
        pat = 2'd2;
        for (int i = 0; i < 50; i++) begin
            start = (i == 0);
            step();
        end
        start = 1'b0;
        run_table(2);

        // iSTART and iEND together while idle: nothing starts
        do_reset();
        n_bad = 0;
        for (int i = 0; i < 12; i++) begin
            start = (i == 0);
            stop  = (i == 0);
            step();
            if (o_fval || o_lval || o_busy || (o_data != 12'd0)) n_bad++;
        end
        start = 1'b0; stop = 1'b0;
        chk("idle_start_end", 32'(n_bad), 32'd0);

        // iEND followed by iSTART in the same frame: free-running continues
        do_reset();
        pat = 2'd0;
        for (int i = 0; i < 60; i++) begin
            start = (i == 0) || (i == 15);
            stop  = (i == 5);
            step();
        end
        start = 1'b0; stop = 1'b0;
        chk("cancel_vblank_fval", 32'(fv_b[49]), 32'd0);
        chk("cancel_next_fval", 32'(fv_b[50]), 32'd1);
        chk("cancel_next_busy", 32'(bz_b[50]), 32'd1);

        // Free-run, stop requested mid frame 3
        do_reset();
        low_idx = -1;
        for (int i = 0; i < 300; i++) begin
            start = (i == 0);
            stop  = (i == 110);
            step();
            if (i > 0 && !o_busy) begin
                low_idx = i;
                break;
            end
        end
        start = 1'b0; stop = 1'b0;
        chk("stop_busy_fall", 32'(low_idx), 32'd150);
        chk("stop_frames", o_frame, 32'd3);
        n_fv = 0;
        for (int i = 0; i < cur; i++) begin
            if (fv_b[i]) n_fv++;
        end
        chk("stop_fval_total", 32'(n_fv), 32'd135);
        n_bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_fval || o_busy) n_bad++;
        end
        chk("stop_stays_idle", 32'(n_bad), 32'd0);

        // Reset during line 2 of the second frame
        do_reset();
        for (int i = 0; i < 77; i++) begin
            start = (i == 0);
            step();
        end
        start = 1'b0;
        chk("pre_rst_lval", 32'(lv_b[76]), 32'd1);
        chk("pre_rst_y", 32'(yc_b[76]), 32'd2);
        chk("pre_rst_frame", fc_b[76], 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("mid_rst");
        step(); step();
        chk("post_rst_idle", 32'(o_fval), 32'd0);
        cur = 0;
        for (int i = 0; i < 55; i++) begin
            start = (i == 0);
            step();
        end
        start = 1'b0;
        n_fv = 0;
        for (int i = 0; i < 50; i++) begin
            if (fv_b[i]) n_fv++;
        end
        chk("restart_fval_len", 32'(n_fv), 32'd45);
        chk("restart_frame", fc_b[49], 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
